usrt_rx: RTL and testbench

- Receive-side stage directly downstream of the USRT transmitter top level.
- Consumes the transmitter's RTS frame strobe, TXD serial data and the shared usrt_clk bit clock.
- Oversamples all three in the clk domain, deserializes one RTS-delimited frame into a right-aligned parallel word, and reports bit count, a one-cycle valid pulse and a length error checked against the selected frame length.
- Serves as the loopback checker and the receive path of the link.

---
 rtl/usrt_rx.sv | 186 ++++++++++++++++++
 tb/tb_usrt_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/usrt_rx.sv
// rtl/usrt_rx.sv - USRT receiver: oversampled RTS-delimited frame deserializer
//
// Purpose:
//   Samples the transmitter's bit clock, frame strobe and serial data in the
//   clk domain, shifts in one bit per falling usrt_clk edge while RTS is high,
//   and on RTS deassertion publishes the frame right-aligned together with its
//   bit count and a length-error flag.
//
// Ports:
//   clk      in   system clock, all logic on rising edge
//   rst      in   asynchronous active-low reset
//   usrt_clk in   external bit clock (asynchronous to clk)
//   rts      in   frame strobe, high while a frame is sent
//   rxd      in   serial data from the transmitter
//   len_sel  in   expected length select (0: LEN_A, 1: LEN_B)
//   data     out  last received frame, right-aligned
//   bit_cnt  out  number of bits in the last frame
//   valid    out  one-cycle pulse when data/bit_cnt/len_err update
//   len_err  out  last frame length mismatch or overflow
//   busy     out  high while a frame is being received

module usrt_rx #(
    parameter int MAX_BITS = 48,
    parameter int LEN_A    = 32,
    parameter int LEN_B    = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                usrt_clk,
    input  logic                rts,
    input  logic                rxd,
    input  logic                len_sel,
    output logic [MAX_BITS-1:0] data,
    output logic [5:0]          bit_cnt,
    output logic                valid,
    output logic                len_err,
    output logic                busy
);

    localparam logic [5:0] MAX_C   = 6'(MAX_BITS);
    localparam logic [5:0] LEN_A_C = 6'(LEN_A);
    localparam logic [5:0] LEN_B_C = 6'(LEN_B);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Synchronizers: all three inputs see identical latency so that rxd_s is
    // still the mid-bit value when the delayed falling edge is detected.
    logic usrt_s1, usrt_s, usrt_s_d;
    logic rts_s1, rts_s, rts_s_d;
    logic rxd_s1, rxd_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            usrt_s1  <= 1'b0;
            usrt_s   <= 1'b0;
            usrt_s_d <= 1'b0;
            rts_s1   <= 1'b0;
            rts_s    <= 1'b0;
            rts_s_d  <= 1'b0;
            rxd_s1   <= 1'b0;
            rxd_s    <= 1'b0;
        end else begin
            usrt_s1  <= usrt_clk;
            usrt_s   <= usrt_s1;
            usrt_s_d <= usrt_s;
            rts_s1   <= rts;
            rts_s    <= rts_s1;
            rts_s_d  <= rts_s;
            rxd_s1   <= rxd;
            rxd_s    <= rxd_s1;
        end
    end

    logic fall, rts_rise, rts_fall;

    assign fall     = usrt_s_d & ~usrt_s;
    assign rts_rise = rts_s & ~rts_s_d;
    assign rts_fall = ~rts_s & rts_s_d;

    // Frame accumulation registers
    logic [MAX_BITS-1:0] shreg, shreg_next;
    logic [5:0]          cnt, cnt_next;
    logic                ovf, ovf_next;

    // FSM control
    logic do_clear;   // start a fresh frame this cycle
    logic do_sample;  // a bit is offered this cycle
    logic do_done;    // publish the finished frame

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_sample  = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (rts_rise) begin
                    do_clear   = 1'b1;
                    do_sample  = fall;
                    state_next = RECV;
                end
            end
            RECV: begin
                // rts_fall implies rts_s=0, so a coincident edge is dropped.
                do_sample = fall & rts_s;
                if (rts_fall) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                do_done = 1'b1;
                if (rts_s) begin
                    do_clear   = 1'b1;
                    do_sample  = fall;
                    state_next = RECV;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear happens first so that a coincident sample lands in an empty frame.
    always_comb begin
        shreg_next = do_clear ? '0 : shreg;
        cnt_next   = do_clear ? 6'd0 : cnt;
        ovf_next   = do_clear ? 1'b0 : ovf;
        if (do_sample) begin
            if (cnt_next < MAX_C) begin
                shreg_next = {shreg_next[MAX_BITS-2:0], rxd_s};
                cnt_next   = cnt_next + 6'd1;
            end else begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= 6'd0;
            ovf   <= 1'b0;
        end else begin
            shreg <= shreg_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    // Output registers: updated only in DONE, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data    <= '0;
            bit_cnt <= 6'd0;
            len_err <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= do_done;
            if (do_done) begin
                data    <= shreg;
                bit_cnt <= cnt;
                len_err <= ovf | (cnt != (len_sel ? LEN_B_C : LEN_A_C));
            end
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_usrt_rx.sv
// tb/tb_usrt_rx.sv - directed self-checking bench for usrt_rx

module tb_usrt_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        usrt_clk = 1'b0;
    logic        rts = 1'b0;
    logic        rxd = 1'b0;
    logic        len_sel = 1'b0;
    logic [47:0] data;
    logic [5:0]  bit_cnt;
    logic        valid;
    logic        len_err;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic busy_mid;

    usrt_rx #(.MAX_BITS(48), .LEN_A(32), .LEN_B(48)) dut (
        .clk      (clk),
        .rst      (rst),
        .usrt_clk (usrt_clk),
        .rts      (rts),
        .rxd      (rxd),
        .len_sel  (len_sel),
        .data     (data),
        .bit_cnt  (bit_cnt),
        .valid    (valid),
        .len_err  (len_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transmitter model: TXD changes on usrt_clk rise, 8 clk per bit, MSB first.
    task automatic send_frame(input logic [63:0] val, input int n);
        rts = 1'b1;
        tick(4);
        for (int i = n - 1; i >= 0; i--) begin
            usrt_clk = 1'b1;
            rxd      = val[i];
            tick(4);
            usrt_clk = 1'b0;
            tick(4);
            if (i == n / 2) busy_mid = busy;
        end
        rts = 1'b0;
        rxd = 1'b0;
    endtask

    // Watches ncyc clk cycles after RTS drops; expects exactly one valid pulse
    // arriving 4 clk edges after the drop.
    task automatic check_frame(input string name, input logic [47:0] exp_data,
                               input logic [5:0] exp_cnt, input logic exp_err,
                               input int ncyc);
        int pulses = 0;
        int lat = -1;
        logic [47:0] got_data = '0;
        logic [5:0]  got_cnt = '0;
        logic        got_err = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (valid) begin
                if (pulses == 0) begin
                    lat      = c - 1;
                    got_data = data;
                    got_cnt  = bit_cnt;
                    got_err  = len_err;
                end
                pulses++;
            end
        end
        chk({name, ".pulses"}, 64'(pulses), 64'd1);
        chk({name, ".latency"}, 64'(lat), 64'd4);
        chk({name, ".data"}, {16'd0, got_data}, {16'd0, exp_data});
        chk({name, ".bit_cnt"}, {58'd0, got_cnt}, {58'd0, exp_cnt});
        chk({name, ".len_err"}, {63'd0, got_err}, {63'd0, exp_err});
        chk({name, ".busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_quiet(input string name, input int ncyc);
        int pulses = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk({name, ".no_valid"}, 64'(pulses), 64'd0);
        chk({name, ".busy"}, {63'd0, busy}, 64'd0);
        chk({name, ".data"}, {16'd0, data}, 64'd0);
        chk({name, ".bit_cnt"}, {58'd0, bit_cnt}, 64'd0);
        chk({name, ".len_err"}, {63'd0, len_err}, 64'd0);
    endtask

    initial begin
        // Reset held while the link is active
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            usrt_clk = ~usrt_clk;
            rts      = ~rts;
            rxd      = ~rxd;
            tick(3);
        end
        chk("rst.data", {16'd0, data}, 64'd0);
        chk("rst.bit_cnt", {58'd0, bit_cnt}, 64'd0);
        chk("rst.valid", {63'd0, valid}, 64'd0);
        chk("rst.len_err", {63'd0, len_err}, 64'd0);
        chk("rst.busy", {63'd0, busy}, 64'd0);
        usrt_clk = 1'b0;
        rts      = 1'b0;
        rxd      = 1'b0;
        tick(2);
        rst = 1'b1;
        check_quiet("idle", 30);

        // Nominal 32-bit frame
        len_sel = 1'b0;
        send_frame(64'hA5C3_0F96, 32);
        chk("nom32.busy_mid", {63'd0, busy_mid}, 64'd1);
        check_frame("nom32", 48'h0000_A5C3_0F96, 6'd32, 1'b0, 20);

        // 48-bit frame, both length selections
        len_sel = 1'b1;
        send_frame(64'hFFFF_0000_1234, 48);
        check_frame("f48_sel1", 48'hFFFF_0000_1234, 6'd48, 1'b0, 20);
        len_sel = 1'b0;
        send_frame(64'hFFFF_0000_1234, 48);
        check_frame("f48_sel0", 48'hFFFF_0000_1234, 6'd48, 1'b1, 20);

        // Overflow: 50 bits, last two dropped
        len_sel = 1'b1;
        send_frame((64'h8000_0000_0001 << 2) | 64'd3, 50);
        check_frame("ovf", 48'h8000_0000_0001, 6'd48, 1'b1, 20);

        // Short frame 10110
        len_sel = 1'b0;
        send_frame(64'h16, 5);
        check_frame("short5", 48'h16, 6'd5, 1'b1, 20);

        // Empty frame: RTS pulse of 8 clk with usrt_clk idle
        rts = 1'b1;
        tick(8);
        rts = 1'b0;
        check_frame("empty", 48'h0, 6'd0, 1'b1, 20);

        // Back-to-back frames, 2 usrt periods (16 clk) of RTS low between
        send_frame(64'hA5C3_0F96, 32);
        check_frame("b2b_1", 48'h0000_A5C3_0F96, 6'd32, 1'b0, 16);
        send_frame(64'h1234_5678, 32);
        check_frame("b2b_2", 48'h0000_1234_5678, 6'd32, 1'b0, 20);

        // Async reset after 10 bits of a frame
        rts = 1'b1;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            usrt_clk = 1'b1;
            rxd      = i[0];
            tick(4);
            usrt_clk = 1'b0;
            tick(4);
        end
        chk("midrst.busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #2;
        chk("midrst.data", {16'd0, data}, 64'd0);
        chk("midrst.busy", {63'd0, busy}, 64'd0);
        rts = 1'b0;
        rxd = 1'b0;
        tick(2);
        rst = 1'b1;
        check_quiet("midrst_after", 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
